instr_fetch_sequencer: RTL and testbench

INSTR_FETCH_SEQUENCER -- requirements
Module: instr_fetch_sequencer

---
 rtl/instr_fetch_sequencer.sv | 175 +++++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// instr_fetch_sequencer
//
// Fetches fixed two-byte instructions from a byte-wide program ROM, presents
// each one to the control unit for a single EXEC cycle, and then either
// continues sequentially, branches to the operand, or halts.
//
// Instruction format:
//   byte0 = {3'b000, opcode[4:0]}   (nonzero upper bits => illegal, run as NOP)
//   byte1 = operand
//
// Ports:
//   clk          in   1  system clock, rising edge
//   rst_n        in   1  asynchronous active-low reset
//   rom_req      out  1  program-ROM read request (high in both fetch states)
//   rom_addr     out  8  program-ROM byte address, always equal to pc
//   rom_ack      in   1  ROM data valid; only looked at while fetching
//   rom_data     in   8  ROM read byte, valid when rom_ack=1
//   PC_LOAD      in   1  control unit: branch to operand (EXEC only)
//   HALT         in   1  control unit: stop the sequencer (EXEC only)
//   opcode       out  5  decoded opcode of the instruction being executed
//   operand      out  8  operand of the instruction being executed
//   instr_valid  out  1  one-cycle pulse marking the EXEC cycle
//   illegal      out  1  EXEC instruction had nonzero opcode-byte bits [7:5]
//   halted       out  1  sequencer stopped, leaves only through rst_n
//   pc           out  8  program counter (wraps FF -> 00)
// -----------------------------------------------------------------------------
module instr_fetch_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    output logic       rom_req,
    output logic [7:0] rom_addr,
    input  logic       rom_ack,
    input  logic [7:0] rom_data,
    input  logic       PC_LOAD,
    input  logic       HALT,
    output logic [4:0] opcode,
    output logic [7:0] operand,
    output logic       instr_valid,
    output logic       illegal,
    output logic       halted,
    output logic [7:0] pc
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH_OP  = 3'd1,
        ST_FETCH_ARG = 3'd2,
        ST_EXEC      = 3'd3,
        ST_HALTED    = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  pc_r;
    logic        rom_req_r;
    logic [7:0]  op_stage_r;
    logic [4:0]  opcode_r;
    logic [7:0]  operand_r;
    logic        instr_valid_r;
    logic        illegal_r;
    logic        halted_r;

    // Opcode bytes reserve bits [7:5]; anything set there is not a real opcode.
    function automatic logic opcode_byte_illegal(input logic [7:0] op_byte);
        return (op_byte[7:5] != 3'b000);
    endfunction

    // Opcode actually handed to the control unit: illegal bytes become NOP.
    function automatic logic [4:0] opcode_decode(input logic [7:0] op_byte);
        logic [4:0] dec;
        if (opcode_byte_illegal(op_byte)) begin
            dec = 5'b00000;
        end else begin
            dec = op_byte[4:0];
        end
        return dec;
    endfunction

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= 8'h00;
            rom_req_r     <= 1'b0;
            op_stage_r    <= 8'h00;
            opcode_r      <= 5'b00000;
            operand_r     <= 8'h00;
            instr_valid_r <= 1'b0;
            illegal_r     <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            // instr_valid and illegal are single-cycle pulses; only the
            // FETCH_ARG -> EXEC transition raises them.
            instr_valid_r <= 1'b0;
            illegal_r     <= 1'b0;

            case (state_r)
                ST_IDLE: begin
                    // First edge after reset release: start fetching at pc=0.
                    // Any stray ack seen here belongs to an abandoned request.
                    state_r   <= ST_FETCH_OP;
                    rom_req_r <= 1'b1;
                end

                ST_FETCH_OP: begin
                    if (rom_ack) begin
                        op_stage_r <= rom_data;
                        pc_r       <= pc_r + 8'd1;
                        state_r    <= ST_FETCH_ARG;
                    end else begin
                        // Wait states: request and address stay put.
                        state_r    <= ST_FETCH_OP;
                    end
                end

                ST_FETCH_ARG: begin
                    if (rom_ack) begin
                        // The operand byte arrives on the commit edge itself,
                        // so it goes straight into the output register while
                        // the opcode comes from the staged first byte.
                        pc_r          <= pc_r + 8'd1;
                        state_r       <= ST_EXEC;
                        rom_req_r     <= 1'b0;
                        opcode_r      <= opcode_decode(op_stage_r);
                        operand_r     <= rom_data;
                        illegal_r     <= opcode_byte_illegal(op_stage_r);
                        instr_valid_r <= 1'b1;
                    end else begin
                        state_r       <= ST_FETCH_ARG;
                    end
                end

                ST_EXEC: begin
                    // HALT outranks PC_LOAD; pc is left where it is on halt.
                    if (HALT) begin
                        state_r   <= ST_HALTED;
                        halted_r  <= 1'b1;
                        rom_req_r <= 1'b0;
                    end else if (PC_LOAD) begin
                        pc_r      <= operand_r;
                        state_r   <= ST_FETCH_OP;
                        rom_req_r <= 1'b1;
                    end else begin
                        state_r   <= ST_FETCH_OP;
                        rom_req_r <= 1'b1;
                    end
                end

                ST_HALTED: begin
                    // Terminal until rst_n; the ROM interface is ignored.
                    state_r   <= ST_HALTED;
                    halted_r  <= 1'b1;
                    rom_req_r <= 1'b0;
                end

                default: begin
                    // Unreachable encoding: fall back to a clean restart.
                    state_r   <= ST_IDLE;
                    rom_req_r <= 1'b0;
                    halted_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rom_req     = rom_req_r;
    assign rom_addr    = pc_r;
    assign pc          = pc_r;
    assign opcode      = opcode_r;
    assign operand     = operand_r;
    assign instr_valid = instr_valid_r;
    assign illegal     = illegal_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_sequencer
//
// Directed scenarios followed by a randomized run. A byte-array ROM supplies
// data; the reference model tracks the fetch address, the two fetched bytes
// and the committed instruction at the transaction level, and the bench
// compares the DUT against it on every falling edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_sequencer;

    logic       clk;
    logic       rst_n;
    logic       rom_req;
    logic [7:0] rom_addr;
    logic       rom_ack;
    logic [7:0] rom_data;
    logic       PC_LOAD;
    logic       HALT;
    logic [4:0] opcode;
    logic [7:0] operand;
    logic       instr_valid;
    logic       illegal;
    logic       halted;
    logic [7:0] pc;

    instr_fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rom_req     (rom_req),
        .rom_addr    (rom_addr),
        .rom_ack     (rom_ack),
        .rom_data    (rom_data),
        .PC_LOAD     (PC_LOAD),
        .HALT        (HALT),
        .opcode      (opcode),
        .operand     (operand),
        .instr_valid (instr_valid),
        .illegal     (illegal),
        .halted      (halted),
        .pc          (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program ROM contents
    logic [7:0] rom_mem [256];

    // Reference model
    logic [7:0] m_pc;       // next fetch address / program counter
    int         m_nbytes;   // bytes of current instruction already fetched
    bit         m_exec;     // next observed cycle should be EXEC
    bit         m_halted;
    logic [7:0] m_byte0;
    logic [7:0] m_byte1;
    logic [4:0] exp_opc;    // last committed opcode
    logic [7:0] exp_arg;    // last committed operand

    int total_cnt;
    int bad_cnt;
    int halt_cycles;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_init();
        m_pc     = 8'h00;
        m_nbytes = 0;
        m_exec   = 1'b0;
        m_halted = 1'b0;
        exp_opc  = 5'h00;
        exp_arg  = 8'h00;
        halt_cycles = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   {31'd0, rom_req},     32'd0);
        check({tag, "_addr"},  {24'd0, rom_addr},    32'd0);
        check({tag, "_pc"},    {24'd0, pc},          32'd0);
        check({tag, "_opc"},   {27'd0, opcode},      32'd0);
        check({tag, "_arg"},   {24'd0, operand},     32'd0);
        check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
        check({tag, "_ill"},   {31'd0, illegal},     32'd0);
        check({tag, "_halt"},  {31'd0, halted},      32'd0);
    endtask

    // Reset, check the reset state, release with a stray late ack present,
    // and leave the bench at the falling edge of the first FETCH_OP cycle.
    task automatic do_reset();
        rst_n = 1'b0; rom_ack = 1'b0; PC_LOAD = 1'b0; HALT = 1'b0; rom_data = 8'h00;
        @(posedge clk); @(negedge clk);
        check_all_zero("rst");
        rst_n = 1'b1; rom_ack = 1'b1; rom_data = 8'hE7;
        #1;
        check("idle_req", {31'd0, rom_req}, 32'd0);
        @(posedge clk); @(negedge clk);
        model_init();
    endtask

    // One cycle: compare against the model, drive the next inputs, advance.
    task automatic step(input bit ack, input bit load, input bit halt);
        if (m_halted) begin
            check("hlt_req",   {31'd0, rom_req},     32'd0);
            check("hlt_flag",  {31'd0, halted},      32'd1);
            check("hlt_valid", {31'd0, instr_valid}, 32'd0);
            check("hlt_pc",    {24'd0, pc},          {24'd0, m_pc});
            halt_cycles++;
            rom_data = 8'($urandom);
        end else if (m_exec) begin
            exp_opc = (m_byte0[7:5] != 3'b000) ? 5'h00 : m_byte0[4:0];
            exp_arg = m_byte1;
            check("ex_valid", {31'd0, instr_valid}, 32'd1);
            check("ex_opc",   {27'd0, opcode},      {27'd0, exp_opc});
            check("ex_arg",   {24'd0, operand},     {24'd0, exp_arg});
            check("ex_ill",   {31'd0, illegal},     {31'd0, (m_byte0[7:5] != 3'b000)});
            check("ex_pc",    {24'd0, pc},          {24'd0, m_pc});
            check("ex_req",   {31'd0, rom_req},     32'd0);
            check("ex_halt",  {31'd0, halted},      32'd0);
            rom_data = 8'($urandom);
            if (halt) begin
                m_halted = 1'b1;
            end else if (load) begin
                m_pc = exp_arg;
            end
            m_exec   = 1'b0;
            m_nbytes = 0;
        end else begin
            check("f_req",   {31'd0, rom_req},     32'd1);
            check("f_addr",  {24'd0, rom_addr},    {24'd0, m_pc});
            check("f_pc",    {24'd0, pc},          {24'd0, m_pc});
            check("f_valid", {31'd0, instr_valid}, 32'd0);
            check("f_ill",   {31'd0, illegal},     32'd0);
            check("f_halt",  {31'd0, halted},      32'd0);
            check("f_opc",   {27'd0, opcode},      {27'd0, exp_opc});
            check("f_arg",   {24'd0, operand},     {24'd0, exp_arg});
            if (ack) begin
                rom_data = rom_mem[m_pc];
                if (m_nbytes == 0) begin
                    m_byte0  = rom_mem[m_pc];
                    m_nbytes = 1;
                end else begin
                    m_byte1 = rom_mem[m_pc];
                    m_exec  = 1'b1;
                end
                m_pc = m_pc + 8'd1;
            end else begin
                rom_data = 8'($urandom);
            end
        end
        rom_ack = ack;
        PC_LOAD = load;
        HALT    = halt;
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        rst_n = 1'b0; rom_ack = 1'b0; rom_data = 8'h00; PC_LOAD = 1'b0; HALT = 1'b0;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'h00;
        model_init();
        @(negedge clk);
        #1;
        check_all_zero("por");

        // Zero-wait fetch of {01, 2A}
        rom_mem[8'h00] = 8'h01; rom_mem[8'h01] = 8'h2A;
        rom_mem[8'h02] = 8'h03; rom_mem[8'h03] = 8'h77;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("t20_valid", {31'd0, instr_valid}, 32'd1);
        check("t20_opc",   {27'd0, opcode},      32'h01);
        check("t20_arg",   {24'd0, operand},     32'h2A);
        check("t20_pc",    {24'd0, pc},          32'h02);
        step(1'b0, 1'b0, 1'b0);
        check("t22_seq_addr", {24'd0, rom_addr}, 32'h02);

        // Three-cycle ack delay in FETCH_OP, with branch/halt requests ignored
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("t21_addr", {24'd0, rom_addr}, 32'h02);
        check("t21_opc",  {27'd0, opcode},   32'h01);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        // Branch to operand 40, then illegal opcode E3 followed by legal 05
        rom_mem[8'h00] = 8'h10; rom_mem[8'h01] = 8'h40;
        rom_mem[8'h40] = 8'hE3; rom_mem[8'h41] = 8'h5A;
        rom_mem[8'h42] = 8'h05; rom_mem[8'h43] = 8'hC3;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("t22_br_addr", {24'd0, rom_addr}, 32'h40);
        check("t22_br_pc",   {24'd0, pc},       32'h40);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("t24_ill",  {31'd0, illegal}, 32'd1);
        check("t24_nop",  {27'd0, opcode},  32'h00);
        step(1'b0, 1'b0, 1'b0);
        check("t24_ill_low", {31'd0, illegal}, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check("t24_ill2", {31'd0, illegal}, 32'd0);
        check("t24_opc2", {27'd0, opcode},  32'h05);
        step(1'b0, 1'b0, 1'b0);

        // Branch to FF with pc wrap, then reset during FETCH_ARG
        rom_mem[8'h00] = 8'h00; rom_mem[8'h01] = 8'hFF; rom_mem[8'hFF] = 8'h07;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check("t25_ff_addr", {24'd0, rom_addr}, 32'hFF);
        step(1'b1, 1'b0, 1'b0);
        check("t25_wrap_addr", {24'd0, rom_addr}, 32'h00);
        step(1'b1, 1'b0, 1'b0);
        check("t25_pc",  {24'd0, pc},     32'h01);
        check("t25_opc", {27'd0, opcode}, 32'h07);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_all_zero("t25_async");

        // Halt, hold under a toggling ack, then restart from 00
        rom_mem[8'h00] = 8'h02; rom_mem[8'h01] = 8'h99;
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) step(i[0], 1'b0, 1'b0);
        check("t23_halted", {31'd0, halted}, 32'd1);
        do_reset();
        check("t23_restart_addr", {24'd0, rom_addr}, 32'h00);
        check("t23_restart_req",  {31'd0, rom_req},  32'd1);

        // Randomized run over random ROM contents
        for (int i = 0; i < 256; i++) begin
            rom_mem[i] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom);
        end
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            if (m_halted && halt_cycles > 4) begin
                do_reset();
            end else begin
                step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 3);
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
